mc_regfile: RTL and testbench
=============================

Name: mc_regfile

Overview:
- Register file for the multicycle CPU datapath, and the responder side of the regfile read/write port interface.
- Provides 2 read ports with registered outputs that feed the A/B operand latches, and 1 write port.
- Register 0 is hardwired to zero.
- On reset, a built-in clear sequencer zeroes every storage entry before the block accepts traffic.
- Optional same-cycle write-to-read bypass.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 1, 1 = a read returns data written on the same edge; 0 = the read returns the old value.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst_n  input  1  synchronous active-low reset.
- ReadRegister1  input  ADDR_W  read port 1 address.
- ReadRegister2  input  ADDR_W  read port 2 address.
- ReadEn  input  1  capture both read ports on this edge.
- ReadData1  output  WIDTH  registered read data, port 1.
- ReadData2  output  WIDTH  registered read data, port 2.
- ReadValid  output  1  one-cycle pulse: ReadData1/2 updated by the previous edge.
- WriteRegister  input  ADDR_W  write address.
- WriteData  input  WIDTH  write data.
- RegWrite  input  1  write enable.
- Ready  output  1  high once clear is done; traffic is accepted only while high.

Behaviour:
- Reset: Rst_n low at posedge takes effect on that edge.
  - state <= CLEAR, clr_idx <= 1.
  - Ready, ReadValid, ReadData1, ReadData2 <= 0.
  - Storage contents are not touched on the reset edge itself.
- Rst_n low for multiple cycles holds the block in that reset condition.
- States:
  - CLEAR: each edge writes 0 to entry clr_idx and increments clr_idx.
    - On the edge that writes entry DEPTH-1, go to READY and set Ready <= 1.
    - CLEAR lasts DEPTH-1 edges (31 with defaults); Ready rises on the 31st edge after Rst_n returns high.
  - READY: terminal until the next reset.
- During CLEAR:
  - RegWrite and ReadEn are ignored; nothing is written or captured.
  - ReadValid stays 0 and ReadData1/2 stay 0.
- Entry 0 has no storage flop and always reads 0. A write to address 0 is silently dropped; no error is raised.
- Write (READY): at posedge, if RegWrite=1 and WriteRegister!=0, entry[WriteRegister] <= WriteData. RegWrite=0 leaves all entries unchanged regardless of WriteRegister/WriteData.
- Read (READY):
  - At posedge with ReadEn=1, ReadDataN <= value of entry[ReadRegisterN], and ReadValid <= 1 for exactly one cycle.
  - ReadEn=0 gives ReadValid <= 0, and ReadData1/2 hold their last values.
  - Latency is 1 edge from request to data.
- Simultaneous write and read of the same nonzero address on one edge:
  - BYPASS=1: ReadDataN <= WriteData.
  - BYPASS=0: ReadDataN <= the old contents.
  - The bypass applies independently per port. Address 0 is never bypassed.
- Both read ports may address the same entry; both return identical data.
- Back-to-back ReadEn on consecutive edges keeps ReadValid high continuously, with fresh data each cycle.
- Reset mid-operation (READY or CLEAR):
  - Re-enters CLEAR, restarts clr_idx at 1, and re-clears all entries.
  - Writes presented on the reset edge are dropped.
- Widths: addresses are unsigned; no width conversion inside the block; WriteData is stored verbatim.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, READY}.
  - Default WIDTH/ADDR_W constants.
  - Constant ZERO_REG = 0.
- Sub-module regfile_clear_seq: holds the state register and clr_idx counter, and outputs clr_we, clr_addr and Ready.
  - The top level muxes the clear write against the user write port.
- Storage array and read/bypass logic stay in mc_regfile.

Test Plan:
- Reset then idle: hold Rst_n=0 2 cycles, release -> Ready=0 for 30 edges, Ready=1 after edge 31; a read of r1..r31 -> all 0.
- After Ready: write 42 to r2 with RegWrite=1, next edge ReadEn=1 with both ports=2 -> ReadData1=ReadData2=42, ReadValid high exactly 1 cycle.
- Write 15 to r2, then WriteData=42 with RegWrite=0 to r2, then read -> 15.
- Write 15 to r0, read r0 on port 1 -> 0. Write 15 to r2 and 42 to r4, read port1=2, port2=4 -> 15/42.
- Same-edge write 99 to r14 with ReadEn on port2=14 (old value 7) -> BYPASS=1 gives 99; a BYPASS=0 instance gives 7; port1=0 on the same edge gives 0.
- Mid-operation reset:
  - Write 42 to r5, pulse Rst_n=0 one cycle -> ReadValid/ReadData=0.
  - ReadEn and RegWrite during CLEAR are ignored.
  - After Ready, r5 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multicycle register file
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset sequencer that walks entries 1..DEPTH-1 writing zero
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              Ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;

    // Entry 0 has no storage, so the walk starts at 1 and ends at the top entry.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= CLEAR;
            clr_idx <= ADDR_W'(1);
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
                state <= READY;
            end
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_idx;
    assign Ready    = (state == READY);

endmodule

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 2-read/1-write register file with r0 hardwired to zero and optional bypass
module mc_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic              ReadEn,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              ReadValid,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic              Ready
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] R0    = ADDR_W'(ZERO_REG);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;
    logic [WIDTH-1:0]  rd1_next;
    logic [WIDTH-1:0]  rd2_next;
    logic [WIDTH-1:0]  mem [1:DEPTH-1];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .Ready    (Ready)
    );

    assign wr_fire = Ready && RegWrite && (WriteRegister != R0);

    // Storage is left alone on a reset edge; the sequencer owns it until Ready.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_fire) begin
                mem[WriteRegister] <= WriteData;
            end
        end
    end

    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (ReadRegister1 != R0) begin
            if ((BYPASS != 0) && wr_fire && (ReadRegister1 == WriteRegister)) begin
                rd1_next = WriteData;
            end else begin
                rd1_next = mem[ReadRegister1];
            end
        end
        if (ReadRegister2 != R0) begin
            if ((BYPASS != 0) && wr_fire && (ReadRegister2 == WriteRegister)) begin
                rd2_next = WriteData;
            end else begin
                rd2_next = mem[ReadRegister2];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            ReadValid <= 1'b0;
        end else if (Ready && ReadEn) begin
            ReadData1 <= rd1_next;
            ReadData2 <= rd2_next;
            ReadValid <= 1'b1;
        end else begin
            ReadValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_regfile.sv
// tb/tb_mc_regfile.sv - randomized reference-model bench for mc_regfile, bypass and no-bypass instances
module tb_mc_regfile;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic        ReadEn, RegWrite;
    logic [31:0] WriteData;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        valid_b, valid_n, ready_b, ready_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [32];
    bit          ref_ready;
    int          ref_clear_cnt;
    logic [31:0] ref_rd1_b, ref_rd2_b, ref_rd1_n, ref_rd2_n;
    bit          ref_valid;

    always #5 Clk = ~Clk;

    mc_regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .ReadEn(ReadEn),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .ReadValid(valid_b),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .Ready(ready_b)
    );

    mc_regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_n (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .ReadEn(ReadEn),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .ReadValid(valid_n),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .Ready(ready_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: a plain array plus a clear counter; r0 is simply never written.
    task automatic model_edge();
        logic [31:0] old1, old2, by1, by2;
        bit wr;
        if (!Rst_n) begin
            ref_ready     = 0;
            ref_clear_cnt = 0;
            ref_valid     = 0;
            ref_rd1_b = 0; ref_rd2_b = 0; ref_rd1_n = 0; ref_rd2_n = 0;
        end else if (!ref_ready) begin
            ref_valid = 0;
            ref_clear_cnt++;
            if (ref_clear_cnt == 31) begin
                foreach (ref_mem[i]) ref_mem[i] = 0;
                ref_ready = 1;
            end
        end else begin
            wr   = RegWrite && (WriteRegister != 0);
            old1 = ref_mem[ReadRegister1];
            old2 = ref_mem[ReadRegister2];
            by1  = (wr && ReadRegister1 == WriteRegister) ? WriteData : old1;
            by2  = (wr && ReadRegister2 == WriteRegister) ? WriteData : old2;
            ref_valid = ReadEn;
            if (ReadEn) begin
                ref_rd1_b = by1; ref_rd2_b = by2;
                ref_rd1_n = old1; ref_rd2_n = old2;
            end
            if (wr) ref_mem[WriteRegister] = WriteData;
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check({tag, ".ready_b"}, 32'(ready_b), 32'(ref_ready));
        check({tag, ".ready_n"}, 32'(ready_n), 32'(ref_ready));
        check({tag, ".valid_b"}, 32'(valid_b), 32'(ref_valid));
        check({tag, ".valid_n"}, 32'(valid_n), 32'(ref_valid));
        check({tag, ".rd1_b"}, rd1_b, ref_rd1_b);
        check({tag, ".rd2_b"}, rd2_b, ref_rd2_b);
        check({tag, ".rd1_n"}, rd1_n, ref_rd1_n);
        check({tag, ".rd2_n"}, rd2_n, ref_rd2_n);
    endtask

    task automatic drive(input string tag, input logic rst, input logic re,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        Rst_n = rst; ReadEn = re; ReadRegister1 = r1; ReadRegister2 = r2;
        RegWrite = we; WriteRegister = wa; WriteData = wd;
        step(tag);
    endtask

    task automatic wait_ready(input string tag, input int expect_edges);
        int n = 0;
        while (!ready_b && n < 40) begin
            drive(tag, 1, 1, 5'd5, 5'd5, 1, 5'd5, 32'hDEAD);
            n++;
        end
        check({tag, ".edges"}, 32'(n), 32'(expect_edges));
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 'x;
        ref_ready = 0; ref_clear_cnt = 0; ref_valid = 0;
        ref_rd1_b = 0; ref_rd2_b = 0; ref_rd1_n = 0; ref_rd2_n = 0;

        drive("rst", 0, 0, 0, 0, 0, 0, 0);
        drive("rst", 0, 0, 0, 0, 0, 0, 0);
        wait_ready("clear", 31);

        for (int a = 1; a < 32; a += 2)
            drive("rd_zero", 1, 1, 5'(a), 5'((a + 1) % 32), 0, 0, 0);

        drive("w42", 1, 0, 0, 0, 1, 5'd2, 32'd42);
        drive("r42", 1, 1, 5'd2, 5'd2, 0, 0, 0);
        check("r42.port1", rd1_b, 32'd42);
        check("r42.port2", rd2_b, 32'd42);
        drive("r42_idle", 1, 0, 0, 0, 0, 0, 0);
        check("r42.pulse", 32'(valid_b), 32'd0);

        drive("w15", 1, 0, 0, 0, 1, 5'd2, 32'd15);
        drive("nowr", 1, 0, 0, 0, 0, 5'd2, 32'd42);
        drive("r15", 1, 1, 5'd2, 5'd0, 0, 0, 0);
        check("r15.port1", rd1_b, 32'd15);

        drive("w_r0", 1, 0, 0, 0, 1, 5'd0, 32'd15);
        drive("r_r0", 1, 1, 5'd0, 5'd0, 0, 0, 0);
        check("r0.port1", rd1_b, 32'd0);
        drive("w2", 1, 0, 0, 0, 1, 5'd2, 32'd15);
        drive("w4", 1, 0, 0, 0, 1, 5'd4, 32'd42);
        drive("r2r4", 1, 1, 5'd2, 5'd4, 0, 0, 0);
        check("r2r4.port1", rd1_b, 32'd15);
        check("r2r4.port2", rd2_b, 32'd42);

        drive("w7", 1, 0, 0, 0, 1, 5'd14, 32'd7);
        drive("byp", 1, 1, 5'd0, 5'd14, 1, 5'd14, 32'd99);
        check("byp.on", rd2_b, 32'd99);
        check("byp.off", rd2_n, 32'd7);
        check("byp.r0", rd1_b, 32'd0);

        drive("w5", 1, 0, 0, 0, 1, 5'd5, 32'd42);
        drive("r5", 1, 1, 5'd5, 5'd5, 0, 0, 0);
        drive("midrst", 0, 1, 5'd5, 5'd5, 1, 5'd6, 32'd77);
        check("midrst.valid", 32'(valid_b), 32'd0);
        check("midrst.data", rd1_b, 32'd0);
        wait_ready("reclear", 31);
        drive("r5_after", 1, 1, 5'd5, 5'd6, 0, 0, 0);
        check("r5_after", rd1_b, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] r1, r2, wa;
            r1 = 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            drive("rand", ($urandom_range(0, 499) != 0), 1'($urandom), r1, r2,
                  1'($urandom), wa, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
